// File: rtl/updn_cnt_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// The optional saturation mode is selected with UPDN_CNT_SAT_EN.
package updn_cnt_pkg;

  localparam logic CTRL_UP = 1'b1;
  localparam logic CTRL_DN = 1'b0;

  // Loads above the modulus are pinned to the top of the range.
  function automatic int unsigned clamp_load(input int unsigned load_val,
                                             input int unsigned max_val);
    return (load_val > max_val) ? max_val : load_val;
  endfunction

endpackage

// File: rtl/updn_cnt_next.sv
// Combinational next-count and wrap/limit calculation for updn_counter_param.
// UPDN_CNT_SAT_EN defined: hold at the limits instead of wrapping.
module updn_cnt_next
  import updn_cnt_pkg::*;
#(
  parameter int          WIDTH   = 3,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             ctrl,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt,
  output logic             nxt_wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] lim_up;
  logic [WIDTH-1:0] lim_dn;

`ifdef UPDN_CNT_SAT_EN
  assign lim_up = MAX_C;
  assign lim_dn = '0;
`else
  assign lim_up = '0;
  assign lim_dn = MAX_C;
`endif

  always_comb begin
    nxt      = count;
    nxt_wrap = 1'b0;
    if (load) begin
      nxt = WIDTH'(clamp_load(32'(load_val), MAX_VAL));
    end else if (en) begin
      case (ctrl)
        CTRL_UP: begin
          // Compare against MAX_VAL, not the all-ones value, so odd moduli never overrun.
          if (count < MAX_C) begin
            nxt = count + WIDTH'(1);
          end else begin
            nxt      = lim_up;
            nxt_wrap = 1'b1;
          end
        end
        CTRL_DN: begin
          if (count != '0) begin
            nxt = count - WIDTH'(1);
          end else begin
            nxt      = lim_dn;
            nxt_wrap = 1'b1;
          end
        end
        default: nxt = count;
      endcase
    end
  end

endmodule

// File: rtl/updn_counter_param.sv
// Parametrised synchronous up/down counter with load, enable and terminal flags.
// Build with UPDN_CNT_SAT_EN defined to saturate at 0/MAX_VAL instead of wrapping.
module updn_counter_param
  import updn_cnt_pkg::*;
#(
  parameter int          WIDTH   = 3,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ctrl,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;

  updn_cnt_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count    (count_q),
    .ctrl     (ctrl),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .nxt      (count_d),
    .nxt_wrap (wrap_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_updn_counter_param.sv
// Self-checking bench for updn_counter_param (WIDTH=3, MAX_VAL=5, RST_VAL=0).
// Honours UPDN_CNT_SAT_EN so the reference model matches the build under test.
module tb_updn_counter_param;

  localparam int W   = 3;
  localparam int MAX = 5;
  localparam int RV  = 0;
`ifdef UPDN_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         en;
  logic         ctrl;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         wrap;
  logic         at_max;
  logic         at_zero;

  int errors = 0;
  int checks = 0;

  int m_count = 0;
  bit m_wrap  = 1'b0;

  updn_counter_param #(
    .WIDTH   (W),
    .MAX_VAL (MAX),
    .RST_VAL (RV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .ctrl     (ctrl),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: counting is arithmetic modulo (MAX+1), or clamped to [0,MAX] when saturating.
  task automatic model_step(input bit r, input bit e, input bit c, input bit l, input int lv);
    if (!r) begin
      m_count = RV;
      m_wrap  = 1'b0;
    end else if (l) begin
      m_count = (lv > MAX) ? MAX : lv;
      m_wrap  = 1'b0;
    end else if (e && c) begin
      m_wrap  = (m_count == MAX);
      m_count = SAT ? ((m_count + 1 > MAX) ? MAX : m_count + 1) : (m_count + 1) % (MAX + 1);
    end else if (e) begin
      m_wrap  = (m_count == 0);
      m_count = SAT ? ((m_count == 0) ? 0 : m_count - 1) : (m_count + MAX) % (MAX + 1);
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  // Apply one cycle of inputs, clock it, and advance the model; sample lands 1 ns after the edge.
  task automatic drive_cycle(input bit r, input bit e, input bit c, input bit l, input int lv);
    rst      = r;
    en       = e;
    ctrl     = c;
    load     = l;
    load_val = W'(lv);
    @(posedge clk);
    #1;
    model_step(r, e, c, l, lv);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive_cycle(0, 1, 1, 1, 3);
      else       drive_cycle(1, 1, 1, 0, 0);
      checks++;
      if ({count, wrap, at_max, at_zero} !== {W'(m_count), m_wrap, m_count == MAX, m_count == 0}) begin
        errors++;
        $display("FAIL reset[%0d]: got cnt=%0d wrap=%0b max=%0b zero=%0b, expected cnt=%0d wrap=%0b max=%0b zero=%0b",
                 i, count, wrap, at_max, at_zero, m_count, m_wrap, m_count == MAX, m_count == 0);
      end
    end
    // Explicit reset value check independent of the model.
    checks++;
    if (count !== W'(RV + 1)) begin
      errors++;
      $display("FAIL reset_release: got cnt=%0d, expected cnt=%0d", count, RV + 1);
    end
  endtask

  task automatic test_count_up();
    drive_cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1, 1, 1, 0, 0);
      checks++;
      if ({count, wrap, at_max, at_zero} !== {W'(m_count), m_wrap, m_count == MAX, m_count == 0}) begin
        errors++;
        $display("FAIL up[%0d]: got cnt=%0d wrap=%0b max=%0b zero=%0b, expected cnt=%0d wrap=%0b max=%0b zero=%0b",
                 i, count, wrap, at_max, at_zero, m_count, m_wrap, m_count == MAX, m_count == 0);
      end
    end
  endtask

  task automatic test_count_down();
    drive_cycle(1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 1, 0, 0, 0);
      checks++;
      if ({count, wrap, at_max, at_zero} !== {W'(m_count), m_wrap, m_count == MAX, m_count == 0}) begin
        errors++;
        $display("FAIL down[%0d]: got cnt=%0d wrap=%0b max=%0b zero=%0b, expected cnt=%0d wrap=%0b max=%0b zero=%0b",
                 i, count, wrap, at_max, at_zero, m_count, m_wrap, m_count == MAX, m_count == 0);
      end
    end
  endtask

  task automatic test_load();
    int lvs[3]  = '{7, 2, 6};
    bit ens[3]  = '{0, 1, 1};
    int want[3] = '{5, 2, 5};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, ens[i], 1, 1, lvs[i]);
      checks++;
      if ({count, wrap} !== {W'(want[i]), 1'b0} || m_count != want[i]) begin
        errors++;
        $display("FAIL load[%0d]: got cnt=%0d wrap=%0b, expected cnt=%0d wrap=0", i, count, wrap, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive_cycle(1, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 0, i[0], 0, 0);
      checks++;
      if ({count, wrap, at_max, at_zero} !== {W'(m_count), m_wrap, m_count == MAX, m_count == 0}) begin
        errors++;
        $display("FAIL hold[%0d]: got cnt=%0d wrap=%0b max=%0b zero=%0b, expected cnt=%0d wrap=%0b max=%0b zero=%0b",
                 i, count, wrap, at_max, at_zero, m_count, m_wrap, m_count == MAX, m_count == 0);
      end
    end
  endtask

  task automatic test_limits();
    drive_cycle(1, 0, 0, 1, 4);
    for (int i = 0; i < 6; i++) begin
      if (i == 3)     drive_cycle(1, 0, 0, 1, 0);
      else if (i > 3) drive_cycle(1, 1, 0, 0, 0);
      else            drive_cycle(1, 1, 1, 0, 0);
      checks++;
      if ({count, wrap, at_max, at_zero} !== {W'(m_count), m_wrap, m_count == MAX, m_count == 0}) begin
        errors++;
        $display("FAIL limit[%0d]: got cnt=%0d wrap=%0b max=%0b zero=%0b, expected cnt=%0d wrap=%0b max=%0b zero=%0b",
                 i, count, wrap, at_max, at_zero, m_count, m_wrap, m_count == MAX, m_count == 0);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(19, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(1, 0) != 0,
                  $urandom_range(7, 0) == 0, int'($urandom_range(7, 0)));
      checks++;
      if ({count, wrap, at_max, at_zero} !== {W'(m_count), m_wrap, m_count == MAX, m_count == 0}) begin
        errors++;
        $display("FAIL rand[%0d]: got cnt=%0d wrap=%0b max=%0b zero=%0b, expected cnt=%0d wrap=%0b max=%0b zero=%0b",
                 i, count, wrap, at_max, at_zero, m_count, m_wrap, m_count == MAX, m_count == 0);
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    ctrl     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold();
    test_limits();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
